// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: drives a req/ack data memory, stalls the
// pipeline while an access is outstanding, and aborts hung accesses.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] writedataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_o,
  output logic [31:0] readdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q, we_q, err_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    be_q;
  logic [1:0]    lane_q;
  logic [2:0]    f3_q;

  logic        valid, aligned, is_byte, is_half;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, shifted, ext_d;

  // funct3[1:0] gives the size; unlisted codes fall through to word.
  always_comb begin
    valid   = MemReadM | MemWriteM;
    is_byte = (funct3M[1:0] == 2'b00);
    is_half = (funct3M[1:0] == 2'b01);
    aligned = is_byte | (is_half ? ~ALUresultM[0] : (ALUresultM[1:0] == 2'b00));
    be_d    = 4'hF;
    wdata_d = writedataM;
    if (is_byte) begin
      be_d    = 4'b0001 << ALUresultM[1:0];
      wdata_d = {4{writedataM[7:0]}};
    end else if (is_half) begin
      be_d    = 4'b0011 << {ALUresultM[1], 1'b0};
      wdata_d = {2{writedataM[15:0]}};
    end
  end

  // Load extension uses the lane/size captured at issue time.
  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ext_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_d = {24'd0, shifted[7:0]};
      3'b101:  ext_d = {16'd0, shifted[15:0]};
      default: ext_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid && aligned) begin
            req_q   <= 1'b1;
            we_q    <= MemWriteM & ~MemReadM;
            addr_q  <= {ALUresultM[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lane_q  <= ALUresultM[1:0];
            f3_q    <= funct3M;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else if (valid) begin
            rdata_q <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            rdata_q <= ext_d;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign misaligned_o = valid & ~aligned;
  // Stall is released in DONE so the pipeline advances for exactly one cycle.
  assign stall_o      = ~reset & (((state_q == IDLE) & valid & aligned) | (state_q == WAIT));
  assign readdata_o   = misaligned_o ? 32'd0 : rdata_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign bus_err_o    = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed test-plan steps then random ops checked
// against a size/lane arithmetic model of the memory stage.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  funct3M = '0;
  logic [31:0] ALUresultM = '0, writedataM = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_o, misaligned_o, bus_err_o;
  logic [31:0] readdata_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUresultM(ALUresultM), .writedataM(writedataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_o(stall_o), .readdata_o(readdata_o), .misaligned_o(misaligned_o),
    .bus_err_o(bus_err_o), .dbg_state_o(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain size/offset arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int nb = nbytes(f3);
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int nb = nbytes(f3);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int nb = nbytes(f3);
    logic [31:0] v, mask;
    v = rd >> (8 * (a % 4));
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 1;
    v = v & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One MEM-stage instruction, from its first cycle through DONE.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_delay, input logic [31:0] rdata);
    bit valid, mis, is_load, done_seen;
    int wait_cyc, exp_wait;
    valid   = rd | wr;
    mis     = valid && ((a % nbytes(f3)) != 0);
    is_load = rd;
    @(negedge clock);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUresultM = a; writedataM = wd;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    check("misaligned", misaligned_o, mis);
    check("stall_first", stall_o, valid && !mis);
    check("req_idle", mem_req, 1'b0);
    check("bus_err_idle", bus_err_o, 1'b0);
    if (mis) check("misaligned_rdata", readdata_o, 32'd0);
    if (!valid || mis) return;
    exp_wait  = (ack_delay < TIMEOUT) ? ack_delay + 1 : TIMEOUT;
    wait_cyc  = 0;
    done_seen = 0;
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      @(negedge clock);
      mem_ack   = (wait_cyc == ack_delay);
      mem_rdata = mem_ack ? rdata : $urandom;
      #1;
      if (!stall_o) begin
        done_seen = 1;
        break;
      end
      check("req_wait", mem_req, 1'b1);
      check("we_wait", mem_we, wr && !rd);
      check("addr_wait", mem_addr, {a[31:2], 2'b00});
      check("be_wait", mem_be, model_be(f3, a));
      if (wr && !rd) check("wdata_wait", mem_wdata, model_wdata(f3, wd));
      wait_cyc++;
    end
    check("done_reached", done_seen, 1'b1);
    check("stall_cycles", 1 + wait_cyc, 1 + exp_wait);
    check("req_done", mem_req, 1'b0);
    check("bus_err_done", bus_err_o, ack_delay >= TIMEOUT);
    if (is_load)
      check("readdata_done", readdata_o,
            (ack_delay < TIMEOUT) ? model_load(f3, a, rdata) : 32'd0);
    @(negedge clock);
    mem_ack = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_rdata", readdata_o, 32'd0);
    check("rst_be", mem_be, 4'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_bus_err", bus_err_o, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Directed test-plan steps, back to back.
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    do_op(1, 0, 3'b000, 32'h203, 32'h0, 0, 32'h80112233);
    do_op(1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h80112233);
    do_op(0, 1, 3'b001, 32'h42, 32'h0000ABCD, 0, 32'h0);
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    do_op(1, 0, 3'b010, 32'h104, 32'h0, TIMEOUT + 3, 32'h0);
    do_op(1, 0, 3'b001, 32'h106, 32'h0, TIMEOUT, 32'h12345678);
    do_op(1, 1, 3'b101, 32'h10A, 32'hFFFF_FFFF, 0, 32'h8001_7FFE);
    do_op(0, 0, 3'b010, 32'h103, 32'h0, 0, 32'h0);

    // Reset in the middle of WAIT, then a late ack.
    @(negedge clock);
    MemReadM = 1'b1; funct3M = 3'b010; ALUresultM = 32'h300; mem_ack = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("req_before_reset", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("req_in_reset", mem_req, 1'b0);
    check("stall_in_reset", stall_o, 1'b0);
    MemReadM = 1'b0;
    @(negedge clock);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    check("stall_late_ack", stall_o, 1'b0);
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    check("req_late_ack", mem_req, 1'b0);
    check("rdata_late_ack", readdata_o, 32'd0);
    do_op(1, 0, 3'b010, 32'h300, 32'h0, 1, 32'h5A5A_A5A5);

    // Random ops against the model.
    for (int n = 0; n < 150; n++) begin
      logic r, w;
      int dly;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 1) : $urandom_range(0, 4);
      do_op(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, dly, $urandom);
    end

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
